duty_meter: RTL

Downstream consumer of the waveform constructor stage. It measures the high time and low time of its square-wave output in pulse-tick units, counting the same tick enable that drives that stage. The host uses it to close the loop: a programmed t_high/t_low pair is read back as meas_high/meas_low. Supports single-shot and continuous measurement, with saturation/timeout reporting.

---
 rtl/duty_meter_pkg.sv | 13 +
 rtl/duty_meter_if.sv | 28 ++
 rtl/duty_meter_sat_counter.sv | 38 +++
 rtl/duty_meter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/duty_meter_pkg.sv
// Shared definitions for the duty meter and the waveform constructor stage it observes.
package duty_meter_pkg;

    localparam int DM_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } dm_state_e;

endpackage

// File: rtl/duty_meter_if.sv
// Host/stimulus side of the duty meter: waveform + tick in, measurement results out.
interface duty_meter_if
    import duty_meter_pkg::*;
#(
    parameter int WIDTH = DM_WIDTH
) ();

    logic             signal_i;
    logic             pulse_i;
    logic             start;
    logic             cont;
    logic [WIDTH-1:0] meas_high;
    logic [WIDTH-1:0] meas_low;
    logic             valid;
    logic             busy;
    logic             overflow;

    modport master (
        output signal_i, pulse_i, start, cont,
        input  meas_high, meas_low, valid, busy, overflow
    );

    modport slave (
        input  signal_i, pulse_i, start, cont,
        output meas_high, meas_low, valid, busy, overflow
    );

endinterface

// File: rtl/duty_meter_sat_counter.sv
// Saturating tick counter: clear loads 0 or 1, increment holds at all-ones.
module duty_meter_sat_counter
    import duty_meter_pkg::*;
#(
    parameter int WIDTH = DM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             clr_val,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign at_max = &cnt_q;
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {{(WIDTH-1){1'b0}}, clr_val};
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/duty_meter.sv
// Measures high/low time of the constructor output in pulse-tick units,
// single-shot or continuous, with sticky saturation/timeout flag.
module duty_meter
    import duty_meter_pkg::*;
#(
    parameter int WIDTH = DM_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    duty_meter_if.slave  bus
);

    dm_state_e        state_q, state_d;
    logic             sig_r_q, sig_r_d;
    logic             sig_d_q, sig_d_d;
    logic             cont_r_q, cont_r_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic [WIDTH-1:0] meas_high_q, meas_high_d;
    logic [WIDTH-1:0] meas_low_q, meas_low_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    logic             cnt_clr, cnt_clr_val, cnt_inc;
    logic [WIDTH-1:0] cnt;
    logic             cnt_at_max;
    logic             rise, fall;

    duty_meter_sat_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .clr_val (cnt_clr_val),
        .inc     (cnt_inc),
        .cnt     (cnt),
        .at_max  (cnt_at_max)
    );

    assign rise = sig_r_q & ~sig_d_q;
    assign fall = ~sig_r_q & sig_d_q;

    always_comb begin
        state_d     = state_q;
        sig_r_d     = bus.signal_i;
        sig_d_d     = sig_r_q;
        cont_r_d    = cont_r_q;
        held_d      = held_q;
        meas_high_d = meas_high_q;
        meas_low_d  = meas_low_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        cnt_clr     = 1'b0;
        cnt_clr_val = 1'b0;
        cnt_inc     = 1'b0;

        // start overrides everything, including a closing rise
        if (bus.start) begin
            state_d    = WAIT_RISE;
            cnt_clr    = 1'b1;
            overflow_d = 1'b0;
            cont_r_d   = bus.cont;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT_RISE: begin
                    if (rise) begin
                        state_d     = MEAS_HIGH;
                        cnt_clr     = 1'b1;
                        cnt_clr_val = bus.pulse_i;
                    end else if (bus.pulse_i) begin
                        if (cnt_at_max) begin
                            overflow_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
                MEAS_HIGH: begin
                    // a tick on the edge cycle belongs to the new phase
                    if (fall) begin
                        held_d      = cnt;
                        cnt_clr     = 1'b1;
                        cnt_clr_val = bus.pulse_i;
                        state_d     = MEAS_LOW;
                    end else if (bus.pulse_i) begin
                        cnt_inc = 1'b1;
                        if (cnt_at_max) overflow_d = 1'b1;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        meas_high_d = held_q;
                        meas_low_d  = cnt;
                        valid_d     = 1'b1;
                        cnt_clr     = 1'b1;
                        cnt_clr_val = bus.pulse_i;
                        state_d     = cont_r_q ? MEAS_HIGH : IDLE;
                    end else if (bus.pulse_i) begin
                        cnt_inc = 1'b1;
                        if (cnt_at_max) overflow_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sig_r_q     <= 1'b0;
            sig_d_q     <= 1'b0;
            cont_r_q    <= 1'b0;
            held_q      <= '0;
            meas_high_q <= '0;
            meas_low_q  <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_r_q     <= sig_r_d;
            sig_d_q     <= sig_d_d;
            cont_r_q    <= cont_r_d;
            held_q      <= held_d;
            meas_high_q <= meas_high_d;
            meas_low_q  <= meas_low_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.meas_high = meas_high_q;
    assign bus.meas_low  = meas_low_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overflow  = overflow_q;

endmodule
